// File: rtl/sram_responder_pkg.sv
// sram_responder_pkg
//   Shared types and constants for the SLC-3 SRAM bus responder.
//   sram_state_t : responder FSM states
//   sram_req_t   : decoded bus request for the current edge
//   LAT_W        : width of the read latency counter (READ_LATENCY <= 7)
//   decode_req() : maps the active-low CE/OE/WE strobes to a request

package sram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2,
    WR_HOLD  = 2'd3
  } sram_state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } sram_req_t;

  localparam int LAT_W = 3;

  // WE low always means write, even with OE also low (bus conflict):
  // the responder must never drive the bus while the master may be driving.
  function automatic sram_req_t decode_req(input logic ce, input logic oe, input logic we);
    sram_req_t r;
    r = REQ_NONE;
    if (!ce && !we)      r = REQ_WRITE;
    else if (!ce && !oe) r = REQ_READ;
    return r;
  endfunction

endpackage

// File: rtl/sram_bytelane_mem.sv
// sram_bytelane_mem
//   Single-port DEPTH x 16 RAM with independent byte write enables.
//   Synchronous write, asynchronous read. Contents are never reset.
//   Ports:
//     clk    in   write clock
//     we     in   write strobe, active high
//     be     in   [1] upper byte, [0] lower byte write enable, active high
//     addr   in   word address (shared by read and write)
//     wdata  in   write word
//     rdata  out  word at addr (combinational)

module sram_bytelane_mem #(
  parameter int DEPTH = 65536,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      if (be[1]) mem[addr][15:8] <= wdata[15:8];
      if (be[0]) mem[addr][7:0]  <= wdata[7:0];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sram_responder.sv
// sram_responder
//   Stand-in for the external SLC-3 board SRAM. Answers the active-low
//   CE/OE/WE/UB/LB bus with a configurable read latency, commits writes
//   when WE/CE is released (or when the address moves under a held WE),
//   honours byte lanes, and raises sticky protocol error flags.
//
//   Build option: define SRAM_RESPONDER_STATS_EN to add saturating
//   rd_count / wr_count outputs.
//
//   Ports:
//     Clk           in     system clock, rising edge
//     Reset         in     synchronous reset, active low
//     CE/OE/WE      in     chip/output/write enable, active low
//     UB/LB         in     upper/lower byte lane enable, active low
//     ADDR[19:0]    in     word address
//     Data[15:0]    inout  data bus, driven only in RD_DRIVE
//     ld_en         in     preload strobe (IDLE with no request only)
//     ld_addr[19:0] in     preload address
//     ld_data[15:0] in     preload word
//     rd_valid      out    Data carries read data
//     conflict_err  out    sticky: CE, OE and WE all low seen
//     oor_err       out    sticky: bus access with ADDR >= DEPTH seen
//     rd_count      out    (stats build) completed read latencies
//     wr_count      out    (stats build) committed writes
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   IDLE     | no access in progress, preload allowed
//   RD_WAIT  | read captured, counting latency on a stable address
//   RD_DRIVE | read data on Data (per enabled lane)
//   WR_HOLD  | write captured, resampling Data/UB/LB until release

module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int          DEPTH        = 65536,
  parameter int          READ_LATENCY = 2,
  parameter logic [15:0] OOR_READ_VAL = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CE,
  input  logic        OE,
  input  logic        WE,
  input  logic        UB,
  input  logic        LB,
  input  logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  input  logic        ld_en,
  input  logic [19:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        rd_valid,
  output logic        conflict_err,
  output logic        oor_err
`ifdef SRAM_RESPONDER_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [20:0]      DEPTH_L = 21'(DEPTH);
  localparam logic [LAT_W-1:0] LAT_L   = LAT_W'(READ_LATENCY);

  sram_state_t      state_q, state_d;
  logic [19:0]      addr_q, addr_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      wdat_q, wdat_d;
  logic             wub_q, wub_d;
  logic             wlb_q, wlb_d;
  logic             conflict_q, oor_q;

  sram_req_t   req;
  logic        addr_oor, cur_oor, ld_oor, addr_same;
  logic        commit, preload, rd_done;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [AW-1:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata, rd_word;
  logic        drv;

  assign req       = decode_req(CE, OE, WE);
  assign addr_oor  = {1'b0, ADDR}    >= DEPTH_L;
  assign cur_oor   = {1'b0, addr_q}  >= DEPTH_L;
  assign ld_oor    = {1'b0, ld_addr} >= DEPTH_L;
  assign addr_same = (ADDR == addr_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wdat_d  = wdat_q;
    wub_d   = wub_q;
    wlb_d   = wlb_q;
    commit  = 1'b0;
    preload = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (req == REQ_READ) begin
          state_d = RD_WAIT;
          addr_d  = ADDR;
          cnt_d   = LAT_W'(1);
        end else if (req == REQ_WRITE) begin
          state_d = WR_HOLD;
          addr_d  = ADDR;
          wdat_d  = Data;
          wub_d   = UB;
          wlb_d   = LB;
        end else if (ld_en && !ld_oor) begin
          preload = 1'b1;
        end
      end
      RD_WAIT: begin
        if (req != REQ_READ) begin
          state_d = IDLE;
        end else if (!addr_same) begin
          addr_d = ADDR;
          cnt_d  = LAT_W'(1);
        end else if (cnt_q >= LAT_L) begin
          state_d = RD_DRIVE;
          rd_done = 1'b1;
        end else begin
          cnt_d = cnt_q + LAT_W'(1);
        end
      end
      RD_DRIVE: begin
        if (req != REQ_READ) begin
          state_d = IDLE;
        end else if (!addr_same) begin
          state_d = RD_WAIT;
          addr_d  = ADDR;
          cnt_d   = LAT_W'(1);
        end
      end
      WR_HOLD: begin
        if (req == REQ_WRITE && addr_same) begin
          wdat_d = Data;
          wub_d  = UB;
          wlb_d  = LB;
        end else begin
          // Commit uses the values sampled while WE was still low.
          commit = !cur_oor;
          if (req == REQ_WRITE) begin
            addr_d = ADDR;
            wdat_d = Data;
            wub_d  = UB;
            wlb_d  = LB;
          end else if (req == REQ_READ) begin
            state_d = RD_WAIT;
            addr_d  = ADDR;
            cnt_d   = LAT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      wdat_q     <= '0;
      wub_q      <= 1'b1;
      wlb_q      <= 1'b1;
      conflict_q <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wdat_q     <= wdat_d;
      wub_q      <= wub_d;
      wlb_q      <= wlb_d;
      conflict_q <= conflict_q | (!CE && !OE && !WE);
      oor_q      <= oor_q | ((req != REQ_NONE) && addr_oor);
    end
  end

  // Preload and commit are exclusive (IDLE vs WR_HOLD), so one port suffices.
  // Reset low suppresses both, discarding any pending write.
  assign mem_we    = (commit | preload) & Reset;
  assign mem_addr  = preload ? ld_addr[AW-1:0] : addr_q[AW-1:0];
  assign mem_be    = preload ? 2'b11 : {~wub_q, ~wlb_q};
  assign mem_wdata = preload ? ld_data : wdat_q;

  sram_bytelane_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (Clk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign rd_word = cur_oor ? OOR_READ_VAL : mem_rdata;

  // Enable comes from registered state; UB/LB only select lanes.
  assign drv  = (state_q == RD_DRIVE);
  assign Data = {(drv && !UB) ? rd_word[15:8] : 8'hzz,
                 (drv && !LB) ? rd_word[7:0]  : 8'hzz};

  assign rd_valid     = drv;
  assign conflict_err = conflict_q;
  assign oor_err      = oor_q;

`ifdef SRAM_RESPONDER_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_done && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (commit && wr_count != 16'hFFFF)  wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CE, OE, WE, UB, LB;
  logic [19:0] ADDR;
  wire  [15:0] Data;
  logic        ld_en;
  logic [19:0] ld_addr;
  logic [15:0] ld_data;
  logic        rd_valid, conflict_err, oor_err;
`ifdef SRAM_RESPONDER_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  logic        tb_drv_en;
  logic [15:0] tb_drv;
  assign Data = tb_drv_en ? tb_drv : 16'hzzzz;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  sram_responder #(
    .DEPTH        (256),
    .READ_LATENCY (2),
    .OOR_READ_VAL (16'h0000)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .CE           (CE),
    .OE           (OE),
    .WE           (WE),
    .UB           (UB),
    .LB           (LB),
    .ADDR         (ADDR),
    .Data         (Data),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .rd_valid     (rd_valid),
    .conflict_err (conflict_err),
    .oor_err      (oor_err)
`ifdef SRAM_RESPONDER_STATS_EN
    ,
    .rd_count     (rd_count),
    .wr_count     (wr_count)
`endif
  );

  typedef struct {
    logic        ce, oe, we, ub, lb;
    logic [19:0] addr;
    logic        drv;
    logic [15:0] wd;
    logic        exp_rv;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t rd(input logic [19:0] a, input logic rv, input logic [15:0] d);
    vec_t v;
    v = '{ce:1'b0, oe:1'b0, we:1'b1, ub:1'b0, lb:1'b0, addr:a, drv:1'b0, wd:16'h0,
          exp_rv:rv, exp_data:d};
    return v;
  endfunction

  function automatic vec_t wr(input logic [19:0] a, input logic ub, input logic lb,
                              input logic [15:0] d);
    vec_t v;
    v = '{ce:1'b0, oe:1'b1, we:1'b0, ub:ub, lb:lb, addr:a, drv:1'b1, wd:d,
          exp_rv:1'b0, exp_data:16'h0};
    return v;
  endfunction

  function automatic vec_t nop();
    vec_t v;
    v = '{ce:1'b1, oe:1'b1, we:1'b1, ub:1'b1, lb:1'b1, addr:20'h0, drv:1'b0, wd:16'h0,
          exp_rv:1'b0, exp_data:16'h0};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    CE = v.ce; OE = v.oe; WE = v.we; UB = v.ub; LB = v.lb; ADDR = v.addr;
    tb_drv_en = v.drv; tb_drv = v.wd;
    step();
  endtask

  // Bus must be released: a value driven by the bench reads back intact.
  task automatic probe_z(input string nm);
    tb_drv = 16'hC3A5;
    tb_drv_en = 1'b1;
    #1;
    chk(nm, Data, 16'hC3A5);
    tb_drv_en = 1'b0;
  endtask

  task automatic preload(input logic [19:0] a, input logic [15:0] d);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    step();
    ld_en = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1;
    ADDR = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tb_drv_en = 1'b0; tb_drv = '0;
    step(); step();
    chk("reset_rd_valid", {15'd0, rd_valid}, 16'd0);
    chk("reset_conflict", {15'd0, conflict_err}, 16'd0);
    chk("reset_oor", {15'd0, oor_err}, 16'd0);
    probe_z("reset_data_z");
    Reset = 1'b1;
    step();

    preload(20'h0, 16'hBEEF);
    preload(20'h1, 16'h1111);
    preload(20'h2, 16'h2222);
    preload(20'h3, 16'h1234);
    preload(20'h10, 16'hAAAA);

    // preload and read, latency 2
    vt.push_back(rd(20'h3, 0, 0));
    vt.push_back(rd(20'h3, 0, 0));
    vt.push_back(rd(20'h3, 1, 16'h1234));
    vt.push_back(rd(20'h3, 1, 16'h1234));
    vt.push_back(nop());
    // lower-byte write then read back
    vt.push_back(wr(20'h10, 1'b1, 1'b0, 16'h5678));
    vt.push_back(wr(20'h10, 1'b1, 1'b0, 16'h5678));
    vt.push_back(nop());
    vt.push_back(rd(20'h10, 0, 0));
    vt.push_back(rd(20'h10, 0, 0));
    vt.push_back(rd(20'h10, 1, 16'hAA78));
    vt.push_back(nop());
    // address change one edge into a read restarts latency
    vt.push_back(rd(20'h1, 0, 0));
    vt.push_back(rd(20'h2, 0, 0));
    vt.push_back(rd(20'h2, 0, 0));
    vt.push_back(rd(20'h2, 1, 16'h2222));
    vt.push_back(nop());
    // write release and read on the same edge
    vt.push_back(wr(20'h2, 1'b0, 1'b0, 16'h0F0F));
    vt.push_back(rd(20'h2, 0, 0));
    vt.push_back(rd(20'h2, 0, 0));
    vt.push_back(rd(20'h2, 1, 16'h0F0F));
    vt.push_back(nop());
    // address moves under held WE: both words committed
    vt.push_back(wr(20'h4, 1'b0, 1'b0, 16'h4444));
    vt.push_back(wr(20'h5, 1'b0, 1'b0, 16'h5555));
    vt.push_back(nop());
    vt.push_back(rd(20'h4, 0, 0));
    vt.push_back(rd(20'h4, 0, 0));
    vt.push_back(rd(20'h4, 1, 16'h4444));
    vt.push_back(nop());
    vt.push_back(rd(20'h5, 0, 0));
    vt.push_back(rd(20'h5, 0, 0));
    vt.push_back(rd(20'h5, 1, 16'h5555));
    vt.push_back(nop());

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i]);
      chk($sformatf("vec%0d_rd_valid", i), {15'd0, rd_valid}, {15'd0, vt[i].exp_rv});
      if (vt[i].exp_rv) chk($sformatf("vec%0d_data", i), Data, vt[i].exp_data);
    end
    probe_z("after_vectors_data_z");

    // conflict: CE=OE=WE=0 for one cycle
    CE = 1'b0; OE = 1'b0; WE = 1'b0; UB = 1'b0; LB = 1'b0; ADDR = 20'h20;
    tb_drv_en = 1'b1; tb_drv = 16'h7777;
    step();
    chk("conflict_set", {15'd0, conflict_err}, 16'd1);
    chk("conflict_no_drive", {15'd0, rd_valid}, 16'd0);
    apply(nop());
    step();
    chk("conflict_sticky", {15'd0, conflict_err}, 16'd1);
    probe_z("conflict_data_z");
    Reset = 1'b0;
    step();
    chk("conflict_cleared", {15'd0, conflict_err}, 16'd0);
    Reset = 1'b1;
    step();

    // out of range with DEPTH=256
    apply(wr(20'h100, 1'b0, 1'b0, 16'hDEAD));
    chk("oor_set", {15'd0, oor_err}, 16'd1);
    apply(nop());
    apply(rd(20'h100, 0, 0));
    apply(rd(20'h100, 0, 0));
    apply(rd(20'h100, 0, 0));
    chk("oor_read_valid", {15'd0, rd_valid}, 16'd1);
    chk("oor_read_val", Data, 16'h0000);
    apply(nop());
    apply(rd(20'h0, 0, 0));
    apply(rd(20'h0, 0, 0));
    apply(rd(20'h0, 0, 0));
    chk("oor_mem0_intact", Data, 16'hBEEF);
    chk("oor_sticky", {15'd0, oor_err}, 16'd1);
    apply(nop());

    // reset during RD_DRIVE
    apply(rd(20'h3, 0, 0));
    apply(rd(20'h3, 0, 0));
    apply(rd(20'h3, 0, 0));
    chk("pre_reset_drive", Data, 16'h1234);
`ifdef SRAM_RESPONDER_STATS_EN
    chk("stats_rd_nonzero", {15'd0, (rd_count != 16'd0)}, 16'd1);
`endif
    Reset = 1'b0;
    step();
    chk("rst_drive_rd_valid", {15'd0, rd_valid}, 16'd0);
    chk("rst_oor_cleared", {15'd0, oor_err}, 16'd0);
`ifdef SRAM_RESPONDER_STATS_EN
    chk("stats_rd_cleared", rd_count, 16'd0);
    chk("stats_wr_cleared", wr_count, 16'd0);
`endif
    probe_z("rst_drive_data_z");
    Reset = 1'b1;
    step();
    chk("post_reset_lat1", {15'd0, rd_valid}, 16'd0);
    step();
    chk("post_reset_lat2", {15'd0, rd_valid}, 16'd0);
    step();
    chk("post_reset_valid", {15'd0, rd_valid}, 16'd1);
    chk("post_reset_mem", Data, 16'h1234);
    apply(nop());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
